// File: rtl/gray_port_arbiter.sv
// Round-robin arbiter sharing the gray-image memory read port between NREQ engines,
// with bounded burst locking, tagged read return and a frame-done aggregate.
`timescale 1ns/1ps
module gray_port_arbiter #(
  parameter int NREQ      = 2,
  parameter int BURST_MAX = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic [13:0]          mem_addr,
  input  logic [7:0]           mem_data,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      lock,
  input  logic [14*NREQ-1:0]   addr,
  output logic [NREQ-1:0]      gnt,
  output logic [7:0]           rdata,
  output logic [NREQ-1:0]      rvalid,
  output logic                 src_ready,
  input  logic [NREQ-1:0]      fin,
  output logic                 done
);

  localparam int IW = (NREQ > 2) ? 2 : 1;
  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  logic [1:0]      rr_ptr;
  logic [1:0]      owner;
  logic            owner_valid;
  logic [3:0]      burst_cnt;
  logic [NREQ-1:0] t1;

  logic [13:0]     addr_arr [NREQ];
  logic [2:0]      rr_hit;
  logic            owner_ok;
  logic            gnt_any;
  logic [1:0]      gnt_idx;

  for (genvar g = 0; g < NREQ; g++) begin : g_addr
    assign addr_arr[g] = addr[14*g +: 14];
  end

  // Search from ptr+1 upward with wrap; ptr itself is the last candidate.
  // Returns {found, index}.
  function automatic logic [2:0] rr_search(input logic [NREQ-1:0] r, input logic [1:0] ptr);
    logic [2:0] res;
    int idx;
    res = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (r[idx[IW-1:0]]) res = {1'b1, idx[1:0]};
    end
    return res;
  endfunction

  assign rr_hit   = rr_search(req, rr_ptr);
  assign owner_ok = owner_valid && req[owner[IW-1:0]] && (burst_cnt < BMAX);

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (src_ready) begin
      if (owner_ok) begin
        gnt_any = 1'b1;
        gnt_idx = owner;
      end else if (rr_hit[2]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_hit[1:0];
      end
    end
  end

  assign gnt   = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
  assign rdata = mem_data;

  // A locked owner reaching BURST_MAX has lost this arbitration to round-robin,
  // so whoever wins next starts a fresh burst count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      t1          <= '0;
      rvalid      <= '0;
      src_ready   <= 1'b0;
      done        <= 1'b0;
      rr_ptr      <= 2'(NREQ-1);
      owner       <= '0;
      owner_valid <= 1'b0;
      burst_cnt   <= '0;
    end else begin
      src_ready <= mem_ready;
      rvalid    <= t1;
      done      <= done | (&fin);
      if (gnt_any) begin
        mem_req  <= 1'b1;
        mem_addr <= addr_arr[gnt_idx[IW-1:0]];
        t1       <= gnt;
        rr_ptr   <= gnt_idx;
        if (lock[gnt_idx[IW-1:0]]) begin
          owner       <= gnt_idx;
          owner_valid <= 1'b1;
          if (owner_valid && (owner == gnt_idx) && (burst_cnt < BMAX))
            burst_cnt <= burst_cnt + 4'd1;
          else
            burst_cnt <= 4'd1;
        end else begin
          owner_valid <= 1'b0;
          burst_cnt   <= '0;
        end
      end else begin
        mem_req <= 1'b0;
        t1      <= '0;
        if (owner_valid && !req[owner[IW-1:0]]) begin
          owner_valid <= 1'b0;
          burst_cnt   <= '0;
        end
      end
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
  a_ptr_range:  assert property (@(posedge clk) disable iff (reset) rr_ptr <= 2'(NREQ-1));
  a_cnt_range:  assert property (@(posedge clk) disable iff (reset) burst_cnt <= BMAX);

endmodule

// File: tb/tb_gray_port_arbiter.sv
// Directed bench for gray_port_arbiter (NREQ=2, BURST_MAX=9) with a small memory model.
`timescale 1ns/1ps
module tb_gray_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_ready;
  logic        mem_req;
  logic [13:0] mem_addr;
  logic [7:0]  mem_data = 8'h00;
  logic [1:0]  req;
  logic [1:0]  lock;
  logic [13:0] addr0, addr1;
  logic [1:0]  gnt;
  logic [7:0]  rdata;
  logic [1:0]  rvalid;
  logic        src_ready;
  logic [1:0]  fin;
  logic        done;

  int total = 0;
  int bad   = 0;

  gray_port_arbiter #(.NREQ(2), .BURST_MAX(9)) dut (
    .clk(clk), .reset(reset), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_data(mem_data), .req(req), .lock(lock),
    .addr({addr1, addr0}), .gnt(gnt), .rdata(rdata), .rvalid(rvalid),
    .src_ready(src_ready), .fin(fin), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] memword(input logic [13:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // One-cycle read latency memory
  always @(posedge clk) if (mem_req) mem_data <= memword(mem_addr);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] l, input logic [13:0] a0,
                               input logic [13:0] a1, input logic mr, input logic [1:0] f);
    req = r; lock = l; addr0 = a0; addr1 = a1; mem_ready = mr; fin = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(2'b00, 2'b00, 14'd0, 14'd0, 1'b1, 2'b00);
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  logic [1:0] lg_gnt [10] = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10};
  logic       lg_req [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [1:0] lg_rv  [10] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
  logic [1:0] fn_fin [7]  = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00};
  logic       fn_done[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    logic [1:0] eg;
    logic [1:0] eprev;

    // Reset state and single requester
    reset = 1'b1;
    applyStimulus(2'b01, 2'b00, 14'd129, 14'd0, 1'b0, 2'b00);
    tick();
    #1;
    checkOutput("rst mem_req", 32'(mem_req), 0);
    checkOutput("rst mem_addr", 32'(mem_addr), 0);
    checkOutput("rst rvalid", 32'(rvalid), 0);
    checkOutput("rst src_ready", 32'(src_ready), 0);
    checkOutput("rst done", 32'(done), 0);
    checkOutput("rst gnt", 32'(gnt), 0);
    mem_ready = 1'b1;
    tick();
    #1;
    checkOutput("rst hold src_ready", 32'(src_ready), 0);
    checkOutput("rst hold gnt", 32'(gnt), 0);
    reset = 1'b0;
    tick();
    for (int c = 1; c <= 3; c++) begin
      #1;
      checkOutput($sformatf("single gnt c=%0d", c), 32'(gnt), 32'h1);
      checkOutput($sformatf("single mem_req c=%0d", c), 32'(mem_req), (c >= 2) ? 1 : 0);
      if (c >= 2) checkOutput($sformatf("single mem_addr c=%0d", c), 32'(mem_addr), 129);
      checkOutput($sformatf("single rvalid c=%0d", c), 32'(rvalid), (c >= 3) ? 1 : 0);
      if (c == 3) checkOutput("single rdata", 32'(rdata), 32'(memword(14'd129)));
      tick();
    end
    applyStimulus(2'b00, 2'b00, 14'd129, 14'd0, 1'b1, 2'b00);
    #1;
    checkOutput("single idle gnt", 32'(gnt), 0);
    checkOutput("single tail rvalid c4", 32'(rvalid), 1);
    tick();
    #1;
    checkOutput("single tail mem_req c5", 32'(mem_req), 0);
    checkOutput("single tail rvalid c5", 32'(rvalid), 1);
    tick();
    #1;
    checkOutput("single tail rvalid c6", 32'(rvalid), 0);

    // Round-robin between two requesters
    doReset();
    applyStimulus(2'b11, 2'b00, 14'd10, 14'd20, 1'b1, 2'b00);
    for (int k = 0; k < 6; k++) begin
      #1;
      eg = (k % 2 == 0) ? 2'b01 : 2'b10;
      eprev = (k % 2 == 0) ? 2'b10 : 2'b01;
      checkOutput($sformatf("rr gnt k=%0d", k), 32'(gnt), 32'(eg));
      if (k >= 1) checkOutput($sformatf("rr mem_addr k=%0d", k), 32'(mem_addr), (eprev == 2'b01) ? 10 : 20);
      checkOutput($sformatf("rr rvalid k=%0d", k), 32'(rvalid), (k >= 2) ? 32'(eg) : 0);
      if (k >= 2) checkOutput($sformatf("rr rdata k=%0d", k), 32'(rdata),
                              32'(memword((eg == 2'b01) ? 14'd10 : 14'd20)));
      tick();
    end

    // Burst lock: 9 grants to requester 0, one to requester 1, repeat
    doReset();
    applyStimulus(2'b11, 2'b01, 14'd100, 14'd200, 1'b1, 2'b00);
    for (int k = 0; k < 20; k++) begin
      #1;
      checkOutput($sformatf("lock gnt k=%0d", k), 32'(gnt), (k == 9 || k == 19) ? 32'h2 : 32'h1);
      tick();
    end

    // mem_ready gating during alternating grants
    doReset();
    applyStimulus(2'b11, 2'b00, 14'd30, 14'd40, 1'b1, 2'b00);
    for (int k = 0; k < 10; k++) begin
      mem_ready = !(k >= 2 && k <= 5);
      #1;
      checkOutput($sformatf("ready gnt k=%0d", k), 32'(gnt), 32'(lg_gnt[k]));
      checkOutput($sformatf("ready mem_req k=%0d", k), 32'(mem_req), 32'(lg_req[k]));
      checkOutput($sformatf("ready rvalid k=%0d", k), 32'(rvalid), 32'(lg_rv[k]));
      tick();
    end

    // Reset asserted the cycle after a grant
    doReset();
    applyStimulus(2'b01, 2'b00, 14'd77, 14'd0, 1'b1, 2'b11);
    #1;
    checkOutput("midrst first gnt", 32'(gnt), 1);
    tick();
    #1;
    checkOutput("midrst pre mem_req", 32'(mem_req), 1);
    checkOutput("midrst pre done", 32'(done), 1);
    reset = 1'b1;
    #1;
    checkOutput("midrst mem_req", 32'(mem_req), 0);
    checkOutput("midrst rvalid", 32'(rvalid), 0);
    checkOutput("midrst done", 32'(done), 0);
    checkOutput("midrst gnt", 32'(gnt), 0);
    applyStimulus(2'b11, 2'b00, 14'd5, 14'd6, 1'b1, 2'b00);
    tick();
    #1;
    checkOutput("midrst held rvalid", 32'(rvalid), 0);
    reset = 1'b0;
    tick();
    #1;
    checkOutput("midrst dropped rvalid", 32'(rvalid), 0);
    checkOutput("midrst winner", 32'(gnt), 1);

    // Finish aggregation
    doReset();
    for (int k = 0; k < 7; k++) begin
      applyStimulus(2'b00, 2'b00, 14'd0, 14'd0, 1'b1, fn_fin[k]);
      #1;
      checkOutput($sformatf("fin done k=%0d", k), 32'(done), 32'(fn_done[k]));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
